// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin arbiter sharing one UART transmitter between N_REQ byte requesters.
// Latency: Req_ack one cycle after a grant edge, Tx_valid the cycle after; one byte in flight.
// Backpressure: no grant while can_send=0 or while a frame is active; requesters hold Req_valid.
// Optional: define UART_ARB_TIMEOUT_EN to add the Busy-rise watchdog and the Tx_timeout flag.
module uart_tx_arbiter #(
  parameter int width       = 8,
  parameter int N_REQ       = 4,
  parameter int ID_W        = $clog2(N_REQ),
  parameter int TIMEOUT_CYC = 8
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic [N_REQ-1:0]       Req_valid,
  input  logic [N_REQ*width-1:0] Req_data,
  output logic [N_REQ-1:0]       Req_ack,
  output logic                   Tx_valid,
  output logic [width-1:0]       TX_Data,
  input  logic                   Busy,
  input  logic                   can_send,
  output logic [ID_W-1:0]        Grant_id,
  output logic                   Active
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                   Tx_timeout
`endif
);

  // Reject configurations the arbiter is not built for at elaboration time.
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   sel;
  logic              any_sel;
  logic [ID_W:0]     scan_sum;
  logic [ID_W-1:0]   scan_idx;
  logic [width-1:0]  sel_data;
  logic [ID_W-1:0]   next_ptr;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt;
`endif

  // Pick the first requester at or after rr_ptr, wrapping past N_REQ-1 back to 0.
  always_comb begin
    sel      = '0;
    any_sel  = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(N_REQ)) begin
        scan_sum = scan_sum - (ID_W+1)'(N_REQ);
      end
      scan_idx = scan_sum[ID_W-1:0];
      if (!any_sel && Req_valid[scan_idx]) begin
        any_sel = 1'b1;
        sel     = scan_idx;
      end
    end
  end

  // Byte lane of the selected requester and the pointer that follows the last grant.
  always_comb begin
    sel_data = Req_data[int'(sel)*width +: width];
    next_ptr = (Grant_id == ID_W'(N_REQ-1)) ? '0 : Grant_id + 1'b1;
  end

  // Grant FSM; every output is a register so the UART sees clean strobes.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      Req_ack  <= '0;
      Tx_valid <= 1'b0;
      TX_Data  <= '0;
      Grant_id <= '0;
      Active   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      to_cnt     <= '0;
      Tx_timeout <= 1'b0;
`endif
    end else begin
      Req_ack  <= '0;
      Tx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (any_sel && can_send) begin
            TX_Data       <= sel_data;
            Grant_id      <= sel;
            Req_ack[sel]  <= 1'b1;
            Active        <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          Tx_valid <= 1'b1;
          state    <= WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
          to_cnt   <= '0;
`endif
        end
        WAIT_BUSY: begin
          if (Busy) begin
            state <= WAIT_DONE;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (to_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            // Transmitter never started the frame: flag it and free the channel.
            Tx_timeout <= 1'b1;
            Active     <= 1'b0;
            rr_ptr     <= next_ptr;
            state      <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        WAIT_DONE: begin
          if (!Busy) begin
            Active <= 1'b0;
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: directed self-checking bench for uart_tx_arbiter (4 requesters, 8-bit bytes).
// Latency: inputs driven and outputs sampled on the falling edge, away from the active edge.
// Backpressure: Busy is driven by hand to emulate the UART frame; can_send gates grants.
module tb_uart_tx_arbiter;

  logic        CLK;
  logic        Reset;
  logic [3:0]  Req_valid;
  logic [31:0] Req_data;
  logic [3:0]  Req_ack;
  logic        Tx_valid;
  logic [7:0]  TX_Data;
  logic        Busy;
  logic        can_send;
  logic [1:0]  Grant_id;
  logic        Active;
`ifdef UART_ARB_TIMEOUT_EN
  logic        Tx_timeout;
`endif

  int vectors     = 0;
  int miscompares = 0;

  uart_tx_arbiter #(
    .width(8),
    .N_REQ(4),
    .ID_W(2),
    .TIMEOUT_CYC(8)
  ) dut (
    .CLK(CLK),
    .Reset(Reset),
    .Req_valid(Req_valid),
    .Req_data(Req_data),
    .Req_ack(Req_ack),
    .Tx_valid(Tx_valid),
    .TX_Data(TX_Data),
    .Busy(Busy),
    .can_send(can_send),
    .Grant_id(Grant_id),
    .Active(Active)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .Tx_timeout(Tx_timeout)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete granted frame: ack, strobe, Busy high for a few cycles, Busy fall.
  task automatic frame(input string tag, input int id, input logic [7:0] data, input bit drop);
    int n;
    n = 0;
    while (Req_ack == 4'b0000 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_ack_in_time"}, 32'(n < 40), 32'd1);
    chk({tag, "_ack"}, 32'(Req_ack), 32'(1 << id));
    chk({tag, "_grant"}, 32'(Grant_id), 32'(id));
    chk({tag, "_data"}, 32'(TX_Data), 32'(data));
    chk({tag, "_active"}, 32'(Active), 32'd1);
    chk({tag, "_no_valid_with_ack"}, 32'(Tx_valid), 32'd0);
    if (drop) Req_valid[id] = 1'b0;
    @(negedge CLK);
    chk({tag, "_tx_valid"}, 32'(Tx_valid), 32'd1);
    chk({tag, "_ack_cleared"}, 32'(Req_ack), 32'd0);
    chk({tag, "_tx_data"}, 32'(TX_Data), 32'(data));
    Busy = 1'b1;
    @(negedge CLK);
    chk({tag, "_strobe_one_cycle"}, 32'(Tx_valid), 32'd0);
    repeat (3) @(negedge CLK);
    chk({tag, "_active_busy"}, 32'(Active), 32'd1);
    chk({tag, "_no_ack_busy"}, 32'(Req_ack), 32'd0);
    Busy = 1'b0;
    @(negedge CLK);
    chk({tag, "_active_fall"}, 32'(Active), 32'd0);
    chk({tag, "_idle_no_valid"}, 32'(Tx_valid), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    Reset     = 1'b1;
    Req_valid = 4'b0000;
    Busy      = 1'b0;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
  endtask

  initial begin
    Reset     = 1'b1;
    Req_valid = 4'b0000;
    Req_data  = 32'h0;
    Busy      = 1'b0;
    can_send  = 1'b1;
    repeat (2) @(negedge CLK);

    // Reset values
    chk("rst_ack", 32'(Req_ack), 32'd0);
    chk("rst_tx_valid", 32'(Tx_valid), 32'd0);
    chk("rst_tx_data", 32'(TX_Data), 32'd0);
    chk("rst_grant", 32'(Grant_id), 32'd0);
    chk("rst_active", 32'(Active), 32'd0);
`ifdef UART_ARB_TIMEOUT_EN
    chk("rst_timeout", 32'(Tx_timeout), 32'd0);
`endif
    Reset = 1'b0;

    // Single request on lane 2
    Req_valid = 4'b0100;
    Req_data  = 32'h00A5_0000;
    frame("single", 2, 8'hA5, 1'b1);

    // All four requesting continuously from rr_ptr=0
    do_reset();
    Req_valid = 4'b1111;
    Req_data  = 32'h1312_1110;
    frame("rr0", 0, 8'h10, 1'b0);
    frame("rr1", 1, 8'h11, 1'b0);
    frame("rr2", 2, 8'h12, 1'b0);
    frame("rr3", 3, 8'h13, 1'b0);
    frame("rr4", 0, 8'h10, 1'b0);
    Req_valid = 4'b0000;

    // can_send low blocks the grant
    do_reset();
    Req_valid = 4'b0001;
    Req_data  = 32'h0000_007E;
    can_send  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("cs_low_no_ack", 32'(Req_ack), 32'd0);
      chk("cs_low_no_valid", 32'(Tx_valid), 32'd0);
    end
    can_send = 1'b1;
    @(negedge CLK);
    chk("cs_ack_next", 32'(Req_ack), 32'd1);
    frame("cs", 0, 8'h7E, 1'b1);

    // Reset while the frame is on the wire (rr_ptr is 1 here)
    Req_valid = 4'b0010;
    Req_data  = 32'h0000_5C00;
    @(negedge CLK);
    chk("abort_ack", 32'(Req_ack), 32'b0010);
    Req_valid = 4'b0000;
    @(negedge CLK);
    chk("abort_tx_valid", 32'(Tx_valid), 32'd1);
    Busy = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("abort_active_before", 32'(Active), 32'd1);
    Reset = 1'b1;
    @(negedge CLK);
    chk("abort_ack_zero", 32'(Req_ack), 32'd0);
    chk("abort_valid_zero", 32'(Tx_valid), 32'd0);
    chk("abort_data_zero", 32'(TX_Data), 32'd0);
    chk("abort_grant_zero", 32'(Grant_id), 32'd0);
    chk("abort_active_zero", 32'(Active), 32'd0);
    Reset = 1'b0;
    Busy  = 1'b0;
    // rr_ptr back at 0 picks lane 0 over lane 3
    Req_valid = 4'b1001;
    Req_data  = 32'h3300_0011;
    frame("post_rst", 0, 8'h11, 1'b1);

    // Wrap: grant to 3, then 0 beats 3, then 3
    frame("wrap_a3", 3, 8'h33, 1'b0);
    Req_valid = 4'b1001;
    frame("wrap_b0", 0, 8'h11, 1'b1);
    frame("wrap_c3", 3, 8'h33, 1'b1);

`ifdef UART_ARB_TIMEOUT_EN
    // Busy never rises: watchdog fires after 8 waiting cycles (rr_ptr is 0 here)
    Req_valid = 4'b0100;
    Req_data  = 32'h00C3_0000;
    @(negedge CLK);
    chk("to_ack", 32'(Req_ack), 32'b0100);
    Req_valid = 4'b0000;
    @(negedge CLK);
    chk("to_tx_valid", 32'(Tx_valid), 32'd1);
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      chk("to_not_yet", 32'(Tx_timeout), 32'd0);
    end
    @(negedge CLK);
    chk("to_flag", 32'(Tx_timeout), 32'd1);
    chk("to_active_clr", 32'(Active), 32'd0);
    Req_valid = 4'b0001;
    Req_data  = 32'h0000_005A;
    frame("to_next", 0, 8'h5A, 1'b1);
    chk("to_sticky", 32'(Tx_timeout), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
